iob_cache_fe_arbiter: RTL and testbench
=======================================

Name: iob_cache_fe_arbiter

Overview:
- Two-master round-robin IOb arbiter that sits directly upstream of the cache front-end IOb slave (iob_valid/addr/wdata/wstrb/ready/rvalid/rdata).
- Typical use: instruction and data ports of a CPU sharing one cache instance.
- Tracks outstanding reads in a small in-order ID FIFO, so each read response (rvalid/rdata) returns to the master that issued it.
- Writes (wstrb != 0) produce no response.

Parameters:
ADDR_W, 32, IOb address width (matches cache ADDR_W)
DATA_W, 32, IOb data width (matches cache DATA_W)
RFIFO_DEPTH_W, 2, log2 of outstanding-read ID FIFO depth (depth 4 default); minimum 1

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, synchronous, active-low
cke_i  in  1  clock enable; when low all state holds
s0_iob_valid_i  in  1  master 0 request valid
s0_iob_addr_i  in  ADDR_W  master 0 byte address
s0_iob_wdata_i  in  DATA_W  master 0 write data
s0_iob_wstrb_i  in  DATA_W/8  master 0 write strobes (0 = read)
s0_iob_ready_o  out  1  master 0 request accepted
s0_iob_rvalid_o  out  1  master 0 read data valid
s0_iob_rdata_o  out  DATA_W  master 0 read data
s1_iob_*  same set as s0 for master 1
m_iob_valid_o  out  1  request to cache front end
m_iob_addr_o  out  ADDR_W  forwarded address
m_iob_wdata_o  out  DATA_W  forwarded write data
m_iob_wstrb_o  out  DATA_W/8  forwarded strobes
m_iob_ready_i  in  1  cache accepts request
m_iob_rvalid_i  in  1  cache read data valid
m_iob_rdata_i  in  DATA_W  cache read data
err_o  out  1  sticky: rvalid received with ID FIFO empty

Behaviour:
- Reset (rst_n_i=0 at a clk_i edge, regardless of cke_i):
  - rr_ptr=0 (port 0 has priority next); lock=0; FIFO empty; err_o=0.
  - All s*_ready_o, s*_rvalid_o and m_iob_valid_o are 0 in the cycle after reset.
- Handshake: a request is accepted when m_iob_valid_o & m_iob_ready_i. Each s_k_ready_o = m_iob_ready_i & m_iob_valid_o & (grant==k). Zero added latency.
- Arbitration, combinational, when lock=0:
  - One requester: grant it.
  - Both requesting: grant rr_ptr.
  - None requesting: m_iob_valid_o=0.
- Lock:
  - If m_iob_valid_o=1 and m_iob_ready_i=0, set lock=1 and hold the grant in a register.
  - While lock=1, m_iob_* mirrors the granted port only; the other port cannot preempt.
  - Clear lock on acceptance.
- rr_ptr: on every acceptance, rr_ptr <= ~grant.
- Read gating: if the granted request is a read (wstrb==0) and the FIFO is full (registered count == 2**RFIFO_DEPTH_W), m_iob_valid_o=0 and s*_ready_o=0. A pop in the same cycle does not unblock the push; full is evaluated on the registered count.
- Writes are never gated by FIFO state.
- ID FIFO:
  - Push the grant bit on each accepted read.
  - Pop on m_iob_rvalid_i. Push and pop in the same cycle leave count unchanged.
  - Storage is 1 bit wide, pointers wrap modulo depth, count is RFIFO_DEPTH_W+1 bits.
- Response routing, combinational:
  - s_k_rvalid_o = m_iob_rvalid_i & fifo_nonempty & (head==k).
  - Both s*_rdata_o = m_iob_rdata_i.
- Error: m_iob_rvalid_i with FIFO empty:
  - No s*_rvalid_o asserted, no pop.
  - err_o <= 1, cleared only by reset.
- cke_i=0: rr_ptr, lock, FIFO and err_o hold. Combinational paths remain live; a handshake occurring while cke_i=0 is not recorded, so the integrator holds m_iob_ready_i low when cke_i is low.
- A port may deassert valid only after its ready; if a locked port drops valid, m_iob_valid_o follows it to 0 (protocol violation, undefined).

Decomposition:
- Shared package iob_cache_fe_arbiter_pkg: localparams RFIFO_DEPTH=2**RFIFO_DEPTH_W and PORT_ID_W=1, plus port index constants.
- One natural sub-module: iob_cache_fe_arbiter_idfifo (1-bit-wide synchronous FIFO with count, full/empty, same sync active-low reset and cke).
- Arbiter/lock logic stays in the top.

Test Plan:
- Reset, then s0 read at addr 0x100 with m_ready=1 -> m_valid and s0_ready in the same cycle; cache rvalid with rdata 0xDEADBEEF 2 cycles later -> s0_rvalid=1 with data 0xDEADBEEF, s1_rvalid=0.
- Both ports issue reads every cycle, m_ready=1 -> grants alternate 0,1,0,1 starting at 0; responses in order route 0,1,0,1.
- s1 write held while m_ready=0 for 3 cycles, with s0 valid arriving in cycle 2 -> m_addr stays s1's for all 3 cycles; after acceptance, s0 granted next cycle.
- Four s0 reads accepted with no rvalid (depth 4) -> fifth read blocked (m_valid=0, s0_ready=0) while an s1 write passes; one rvalid -> fifth read accepted the following cycle.
- m_rvalid with FIFO empty -> no s*_rvalid; err_o=1 next cycle, stays 1; rst_n_i low for one edge -> err_o=0.
- Reset asserted with 2 reads outstanding and lock=1 -> FIFO empty, lock=0, rr_ptr=0 after the edge; a late rvalid then sets err_o.

Source files
------------

// File: rtl/iob_cache_fe_arbiter_pkg.sv
// Shared definitions for the two-master cache front-end arbiter.
//   PORT_ID_W       width of a master index held in the read-ID FIFO
//   PORT_S0/PORT_S1 master index constants
//   RFIFO_DEPTH     read-ID FIFO depth for the default RFIFO_DEPTH_W
//   rfifo_depth()   depth for an arbitrary RFIFO_DEPTH_W
//   arb_state_t     free / locked arbitration state
package iob_cache_fe_arbiter_pkg;

    localparam int unsigned PORT_ID_W = 1;

    localparam logic [PORT_ID_W-1:0] PORT_S0 = 1'b0;
    localparam logic [PORT_ID_W-1:0] PORT_S1 = 1'b1;

    localparam int unsigned RFIFO_DEPTH_W_DEFAULT = 2;
    localparam int unsigned RFIFO_DEPTH           = 2 ** RFIFO_DEPTH_W_DEFAULT;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic int unsigned rfifo_depth(input int unsigned depth_w);
        return 1 << depth_w;
    endfunction

endpackage

// File: rtl/iob_cache_fe_arbiter_idfifo.sv
// In-order FIFO of master IDs for outstanding reads.
//   clk_i, rst_n_i  clock, synchronous active-low reset
//   cke_i           clock enable; all state holds while low
//   push_i/push_id_i  enqueue the ID of an accepted read (ignored when full)
//   pop_i           dequeue on a read response (ignored when empty)
//   head_o          ID at the head (valid only when !empty_o)
//   full_o/empty_o  derived from the registered count
module iob_cache_fe_arbiter_idfifo
    import iob_cache_fe_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH_W = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 cke_i,
    input  logic                 push_i,
    input  logic [PORT_ID_W-1:0] push_id_i,
    input  logic                 pop_i,
    output logic [PORT_ID_W-1:0] head_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int unsigned      DEPTH    = rfifo_depth(DEPTH_W);
    localparam logic [DEPTH_W:0] FULL_CNT = (DEPTH_W + 1)'(DEPTH);

    logic [PORT_ID_W-1:0] mem [DEPTH];
    logic [DEPTH_W-1:0]   wr_ptr;
    logic [DEPTH_W-1:0]   rd_ptr;
    logic [DEPTH_W:0]     count;
    logic                 do_push;
    logic                 do_pop;

    assign full_o  = (count == FULL_CNT);
    assign empty_o = (count == '0);
    assign do_push = cke_i & push_i & ~full_o;
    assign do_pop  = cke_i & pop_i & ~empty_o;
    assign head_o  = mem[rd_ptr];

    // Pointers wrap naturally: depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + DEPTH_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + DEPTH_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (DEPTH_W + 1)'(1);
                2'b01:   count <= count - (DEPTH_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while count is nonzero.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_id_i;
    end

endmodule

// File: rtl/iob_cache_fe_arbiter.sv
// Two-master round-robin IOb arbiter in front of the cache front-end slave.
//   clk_i, rst_n_i, cke_i      clock, sync active-low reset, clock enable
//   s0_iob_* / s1_iob_*        master-side IOb slaves (valid/addr/wdata/wstrb
//                              in; ready/rvalid/rdata out)
//   m_iob_*                    IOb master towards the cache
//   err_o                      sticky: read response arrived with no read
//                              outstanding
// A stalled request locks the grant until accepted. Reads record the granted
// master in an ID FIFO so responses return in order to their issuer.
module iob_cache_fe_arbiter
    import iob_cache_fe_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned RFIFO_DEPTH_W = 2
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                cke_i,

    input  logic                s0_iob_valid_i,
    input  logic [ADDR_W-1:0]   s0_iob_addr_i,
    input  logic [DATA_W-1:0]   s0_iob_wdata_i,
    input  logic [DATA_W/8-1:0] s0_iob_wstrb_i,
    output logic                s0_iob_ready_o,
    output logic                s0_iob_rvalid_o,
    output logic [DATA_W-1:0]   s0_iob_rdata_o,

    input  logic                s1_iob_valid_i,
    input  logic [ADDR_W-1:0]   s1_iob_addr_i,
    input  logic [DATA_W-1:0]   s1_iob_wdata_i,
    input  logic [DATA_W/8-1:0] s1_iob_wstrb_i,
    output logic                s1_iob_ready_o,
    output logic                s1_iob_rvalid_o,
    output logic [DATA_W-1:0]   s1_iob_rdata_o,

    output logic                m_iob_valid_o,
    output logic [ADDR_W-1:0]   m_iob_addr_o,
    output logic [DATA_W-1:0]   m_iob_wdata_o,
    output logic [DATA_W/8-1:0] m_iob_wstrb_o,
    input  logic                m_iob_ready_i,
    input  logic                m_iob_rvalid_i,
    input  logic [DATA_W-1:0]   m_iob_rdata_i,

    output logic                err_o
);

    arb_state_t           state_q;
    arb_state_t           state_d;
    logic [PORT_ID_W-1:0] lock_grant_q;
    logic [PORT_ID_W-1:0] lock_grant_d;
    logic [PORT_ID_W-1:0] rr_ptr_q;
    logic [PORT_ID_W-1:0] grant;
    logic                 req_g;
    logic                 read_blocked;
    logic                 accept;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [PORT_ID_W-1:0] fifo_head;
    logic                 err_q;

    // Grant selection: a locked grant wins; otherwise round-robin on conflict.
    always_comb begin
        grant = PORT_S0;
        if (state_q == ARB_LOCKED)
            grant = lock_grant_q;
        else if (s0_iob_valid_i && s1_iob_valid_i)
            grant = rr_ptr_q;
        else if (s1_iob_valid_i)
            grant = PORT_S1;
    end

    assign req_g         = (grant == PORT_S1) ? s1_iob_valid_i : s0_iob_valid_i;
    assign m_iob_addr_o  = (grant == PORT_S1) ? s1_iob_addr_i  : s0_iob_addr_i;
    assign m_iob_wdata_o = (grant == PORT_S1) ? s1_iob_wdata_i : s0_iob_wdata_i;
    assign m_iob_wstrb_o = (grant == PORT_S1) ? s1_iob_wstrb_i : s0_iob_wstrb_i;

    // Reads stall while the ID FIFO is full; a same-cycle pop does not help.
    assign read_blocked  = (m_iob_wstrb_o == '0) & fifo_full;
    assign m_iob_valid_o = req_g & ~read_blocked;
    assign accept        = m_iob_valid_o & m_iob_ready_i;

    assign s0_iob_ready_o = accept & (grant == PORT_S0);
    assign s1_iob_ready_o = accept & (grant == PORT_S1);

    always_comb begin
        state_d      = state_q;
        lock_grant_d = lock_grant_q;
        case (state_q)
            ARB_FREE: begin
                if (m_iob_valid_o && !m_iob_ready_i) begin
                    state_d      = ARB_LOCKED;
                    lock_grant_d = grant;
                end
            end
            ARB_LOCKED: begin
                if (accept) state_d = ARB_FREE;
            end
            default: state_d = ARB_FREE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= ARB_FREE;
            lock_grant_q <= PORT_S0;
            rr_ptr_q     <= PORT_S0;
            err_q        <= 1'b0;
        end else if (cke_i) begin
            state_q      <= state_d;
            lock_grant_q <= lock_grant_d;
            if (accept) rr_ptr_q <= ~grant;
            if (m_iob_rvalid_i && fifo_empty) err_q <= 1'b1;
        end
    end

    iob_cache_fe_arbiter_idfifo #(
        .DEPTH_W (RFIFO_DEPTH_W)
    ) u_idfifo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .cke_i     (cke_i),
        .push_i    (accept & (m_iob_wstrb_o == '0)),
        .push_id_i (grant),
        .pop_i     (m_iob_rvalid_i),
        .head_o    (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign s0_iob_rvalid_o = m_iob_rvalid_i & ~fifo_empty & (fifo_head == PORT_S0);
    assign s1_iob_rvalid_o = m_iob_rvalid_i & ~fifo_empty & (fifo_head == PORT_S1);
    assign s0_iob_rdata_o  = m_iob_rdata_i;
    assign s1_iob_rdata_o  = m_iob_rdata_i;
    assign err_o           = err_q;

endmodule

// File: tb/tb_iob_cache_fe_arbiter.sv
module tb_iob_cache_fe_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n, cke;
    logic        s0_valid, s1_valid;
    logic [31:0] s0_addr, s1_addr, s0_wdata, s1_wdata;
    logic [3:0]  s0_wstrb, s1_wstrb;
    logic        s0_ready, s1_ready, s0_rvalid, s1_rvalid;
    logic [31:0] s0_rdata, s1_rdata;
    logic        m_valid, m_ready, m_rvalid;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic        err;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    iob_cache_fe_arbiter #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .RFIFO_DEPTH_W (2)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .cke_i           (cke),
        .s0_iob_valid_i  (s0_valid),
        .s0_iob_addr_i   (s0_addr),
        .s0_iob_wdata_i  (s0_wdata),
        .s0_iob_wstrb_i  (s0_wstrb),
        .s0_iob_ready_o  (s0_ready),
        .s0_iob_rvalid_o (s0_rvalid),
        .s0_iob_rdata_o  (s0_rdata),
        .s1_iob_valid_i  (s1_valid),
        .s1_iob_addr_i   (s1_addr),
        .s1_iob_wdata_i  (s1_wdata),
        .s1_iob_wstrb_i  (s1_wstrb),
        .s1_iob_ready_o  (s1_ready),
        .s1_iob_rvalid_o (s1_rvalid),
        .s1_iob_rdata_o  (s1_rdata),
        .m_iob_valid_o   (m_valid),
        .m_iob_addr_o    (m_addr),
        .m_iob_wdata_o   (m_wdata),
        .m_iob_wstrb_o   (m_wstrb),
        .m_iob_ready_i   (m_ready),
        .m_iob_rvalid_i  (m_rvalid),
        .m_iob_rdata_i   (m_rdata),
        .err_o           (err)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s0_valid = 0; s0_addr = '0; s0_wdata = '0; s0_wstrb = '0;
        s1_valid = 0; s1_addr = '0; s1_wdata = '0; s1_wstrb = '0;
        m_ready = 0; m_rvalid = 0; m_rdata = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    // Reference model state
    bit          pend [2];
    logic [31:0] paddr [2];
    logic [31:0] pwdata [2];
    logic [3:0]  pwstrb [2];
    int          q [$];
    int          mrr, mlock_port, g;
    bit          mlock, merr, ev, acc, rd;

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        cke = 1;
        idle();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        #2;
        chk1("rst_m_valid", m_valid, 1'b0);
        chk1("rst_s0_ready", s0_ready, 1'b0);
        chk1("rst_s1_ready", s1_ready, 1'b0);
        chk1("rst_s0_rvalid", s0_rvalid, 1'b0);
        chk1("rst_s1_rvalid", s1_rvalid, 1'b0);
        chk1("rst_err", err, 1'b0);

        // Single s0 read, response two cycles later
        s0_valid = 1; s0_addr = 32'h100; m_ready = 1;
        #2;
        chk1("t1_m_valid", m_valid, 1'b1);
        chk32("t1_m_addr", m_addr, 32'h100);
        chk1("t1_s0_ready", s0_ready, 1'b1);
        chk1("t1_s1_ready", s1_ready, 1'b0);
        tick();
        idle();
        tick();
        m_rvalid = 1; m_rdata = 32'hDEADBEEF;
        #2;
        chk1("t1_s0_rvalid", s0_rvalid, 1'b1);
        chk32("t1_s0_rdata", s0_rdata, 32'hDEADBEEF);
        chk1("t1_s1_rvalid", s1_rvalid, 1'b0);
        tick();

        // Both masters reading every cycle: alternate grants from port 0
        do_reset();
        for (int k = 0; k < 4; k++) begin
            s0_valid = 1; s0_addr = 32'h200;
            s1_valid = 1; s1_addr = 32'h300;
            m_ready = 1;
            #2;
            chk1("t2_s0_ready", s0_ready, (k % 2) == 0);
            chk1("t2_s1_ready", s1_ready, (k % 2) == 1);
            chk32("t2_m_addr", m_addr, ((k % 2) == 0) ? 32'h200 : 32'h300);
            tick();
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            m_rvalid = 1; m_rdata = 32'hA0 + 32'(k);
            #2;
            chk1("t2_s0_rvalid", s0_rvalid, (k % 2) == 0);
            chk1("t2_s1_rvalid", s1_rvalid, (k % 2) == 1);
            chk32("t2_s1_rdata", s1_rdata, 32'hA0 + 32'(k));
            tick();
        end
        idle();

        // Lock: s1 write stalled 3 cycles, s0 arrives during the stall
        do_reset();
        s1_valid = 1; s1_addr = 32'h400; s1_wstrb = 4'hF; s1_wdata = 32'h1234;
        #2;
        chk1("t3_m_valid", m_valid, 1'b1);
        chk32("t3_m_addr_c1", m_addr, 32'h400);
        tick();
        s0_valid = 1; s0_addr = 32'h500;
        #2;
        chk32("t3_m_addr_c2", m_addr, 32'h400);
        chk1("t3_s0_ready_c2", s0_ready, 1'b0);
        tick();
        #2;
        chk32("t3_m_addr_c3", m_addr, 32'h400);
        tick();
        m_ready = 1;
        #2;
        chk1("t3_s1_ready", s1_ready, 1'b1);
        chk1("t3_s0_ready_acc", s0_ready, 1'b0);
        chk32("t3_m_wstrb", 32'(m_wstrb), 32'hF);
        tick();
        s1_valid = 0; s1_wstrb = '0;
        #2;
        chk32("t3_m_addr_s0", m_addr, 32'h500);
        chk1("t3_s0_ready", s0_ready, 1'b1);
        tick();
        idle();
        m_rvalid = 1;
        #2;
        chk1("t3_s0_rvalid", s0_rvalid, 1'b1);
        tick();
        idle();

        // FIFO full gating
        do_reset();
        for (int k = 0; k < 4; k++) begin
            s0_valid = 1; s0_addr = 32'h600; m_ready = 1;
            #2;
            chk1("t4_s0_ready_fill", s0_ready, 1'b1);
            tick();
        end
        #2;
        chk1("t4_m_valid_full", m_valid, 1'b0);
        chk1("t4_s0_ready_full", s0_ready, 1'b0);
        tick();
        s1_valid = 1; s1_addr = 32'h700; s1_wstrb = 4'hF;
        #2;
        chk1("t4_s1_write_ready", s1_ready, 1'b1);
        chk32("t4_m_addr_write", m_addr, 32'h700);
        chk1("t4_s0_ready_write", s0_ready, 1'b0);
        tick();
        s1_valid = 0; s1_wstrb = '0;
        m_rvalid = 1; m_rdata = 32'h55;
        #2;
        chk1("t4_m_valid_pop", m_valid, 1'b0);
        chk1("t4_s0_ready_pop", s0_ready, 1'b0);
        chk1("t4_s0_rvalid_pop", s0_rvalid, 1'b1);
        tick();
        m_rvalid = 0;
        #2;
        chk1("t4_m_valid_after", m_valid, 1'b1);
        chk1("t4_s0_ready_after", s0_ready, 1'b1);
        tick();
        idle();

        // Error on response with nothing outstanding
        do_reset();
        m_rvalid = 1; m_rdata = 32'h77;
        #2;
        chk1("t5_s0_rvalid", s0_rvalid, 1'b0);
        chk1("t5_s1_rvalid", s1_rvalid, 1'b0);
        chk1("t5_err_before", err, 1'b0);
        tick();
        m_rvalid = 0;
        #2;
        chk1("t5_err_set", err, 1'b1);
        tick();
        #2;
        chk1("t5_err_sticky", err, 1'b1);
        rst_n = 0; cke = 0;
        tick();
        rst_n = 1; cke = 1;
        #2;
        chk1("t5_err_cleared", err, 1'b0);
        tick();

        // Reset with reads outstanding and lock held
        do_reset();
        s0_valid = 1; s0_addr = 32'h800; m_ready = 1;
        #2;
        chk1("t6_s0_ready", s0_ready, 1'b1);
        tick();
        s0_valid = 0;
        s1_valid = 1; s1_addr = 32'h900;
        #2;
        chk1("t6_s1_ready", s1_ready, 1'b1);
        tick();
        s1_addr = 32'h910; m_ready = 0;
        #2;
        chk32("t6_lock_addr", m_addr, 32'h910);
        tick();
        s0_valid = 1; s0_addr = 32'h810;
        #2;
        chk32("t6_locked_addr", m_addr, 32'h910);
        rst_n = 0;
        tick();
        rst_n = 1;
        #2;
        chk32("t6_post_rst_addr", m_addr, 32'h810);
        tick();
        idle();
        m_rvalid = 1;
        #2;
        chk1("t6_s0_rvalid", s0_rvalid, 1'b0);
        chk1("t6_s1_rvalid", s1_rvalid, 1'b0);
        tick();
        m_rvalid = 0;
        #2;
        chk1("t6_err", err, 1'b1);
        tick();

        // Randomised traffic against the behavioural model
        do_reset();
        pend[0] = 0; pend[1] = 0;
        q.delete();
        mrr = 0; mlock = 0; mlock_port = 0; merr = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 99) < 60) begin
                    pend[p]   = 1;
                    paddr[p]  = $urandom;
                    pwdata[p] = $urandom;
                    pwstrb[p] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                end
            end
            cke      = ($urandom_range(0, 9) != 0);
            m_ready  = cke && ($urandom_range(0, 99) < 65);
            m_rvalid = cke && (q.size() > 0) && ($urandom_range(0, 99) < 40);
            m_rdata  = $urandom;
            s0_valid = pend[0]; s0_addr = paddr[0]; s0_wdata = pwdata[0]; s0_wstrb = pwstrb[0];
            s1_valid = pend[1]; s1_addr = paddr[1]; s1_wdata = pwdata[1]; s1_wstrb = pwstrb[1];
            #2;
            if (mlock)                g = mlock_port;
            else if (pend[0] && pend[1]) g = mrr;
            else                      g = pend[1] ? 1 : 0;
            rd  = (pwstrb[g] == 4'h0);
            ev  = pend[g] && !(rd && q.size() == DEPTH);
            acc = ev && m_ready;
            chk1("rnd_m_valid", m_valid, ev);
            if (ev) begin
                chk32("rnd_m_addr", m_addr, paddr[g]);
                chk32("rnd_m_wdata", m_wdata, pwdata[g]);
                chk32("rnd_m_wstrb", 32'(m_wstrb), 32'(pwstrb[g]));
            end
            chk1("rnd_s0_ready", s0_ready, acc && g == 0);
            chk1("rnd_s1_ready", s1_ready, acc && g == 1);
            chk1("rnd_s0_rvalid", s0_rvalid, m_rvalid && q.size() > 0 && q[0] == 0);
            chk1("rnd_s1_rvalid", s1_rvalid, m_rvalid && q.size() > 0 && q[0] == 1);
            chk32("rnd_s0_rdata", s0_rdata, m_rdata);
            chk1("rnd_err", err, merr);
            tick();
            if (cke) begin
                if (m_rvalid) begin
                    if (q.size() > 0) void'(q.pop_front());
                    else merr = 1;
                end
                if (acc) begin
                    if (rd) q.push_back(g);
                    mrr     = (g == 0) ? 1 : 0;
                    mlock   = 0;
                    pend[g] = 0;
                end else if (ev) begin
                    mlock      = 1;
                    mlock_port = g;
                end
            end
        end
        idle();
        cke = 1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
